// File: rtl/final_cpa_seq_if.sv
// Handshake bundle for final_cpa_seq: row pair in, product and overflow out.
`default_nettype none

interface final_cpa_seq_if #(
  parameter int W = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] row_s;
  logic [W-1:0] row_c;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_p;
  logic         out_ovf;

  modport master (
    output in_valid, row_s, row_c, out_ready,
    input  in_ready, out_valid, out_p, out_ovf
  );

  modport slave (
    input  in_valid, row_s, row_c, out_ready,
    output in_ready, out_valid, out_p, out_ovf
  );
endinterface

`default_nettype wire

// File: rtl/final_cpa_seq.sv
// ============================================================================
// Module      : final_cpa_seq
// Description : Chunk-serial carry-propagate adder that merges the sum/carry
//               rows of a compressor tree into the final product.
//               Optional early finish: define CPA_ZERO_SKIP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module final_cpa_seq #(
  parameter int W     = 16,
  parameter int CHUNK = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  final_cpa_seq_if.slave bus
);

  localparam int NC = W / CHUNK;
  localparam int KW = (NC > 1) ? $clog2(NC) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NC - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [W-1:0]  opa;
  logic [W-1:0]  opb;
  logic          c_top;
  logic [KW-1:0] k;
  logic          carry;
  logic [CHUNK:0] csum;
  logic          last;

  // Operands shift right each ADD cycle, so the live chunk is always at bit 0.
  assign csum = {1'b0, opa[CHUNK-1:0]} + {1'b0, opb[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry};

`ifdef CPA_ZERO_SKIP_EN
  assign last = (k == K_LAST) || (!csum[CHUNK] && ((opa | opb) >> CHUNK) == '0);
`else
  assign last = (k == K_LAST);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.out_p     <= '0;
      bus.out_ovf   <= 1'b0;
      opa           <= '0;
      opb           <= '0;
      c_top         <= 1'b0;
      k             <= '0;
      carry         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            opa          <= bus.row_s;
            opb          <= {bus.row_c[W-2:0], 1'b0};
            c_top        <= bus.row_c[W-1];
            k            <= '0;
            carry        <= 1'b0;
            bus.out_p    <= '0;
            bus.out_ovf  <= 1'b0;
            bus.in_ready <= 1'b0;
            state        <= ADD;
          end
        end
        ADD: begin
          bus.out_p[k*CHUNK +: CHUNK] <= csum[CHUNK-1:0];
          carry <= csum[CHUNK];
          k     <= k + 1'b1;
          opa   <= opa >> CHUNK;
          opb   <= opb >> CHUNK;
          if (last) begin
            // The carry-row MSB was shifted out of opb, so it joins overflow here.
            bus.out_ovf   <= csum[CHUNK] | c_top;
            bus.out_valid <= 1'b1;
            state         <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_final_cpa_seq.sv
// Scoreboard bench for final_cpa_seq: directed corner cases then random traffic.
`default_nettype none

module tb_final_cpa_seq;

  localparam int W     = 16;
  localparam int CHUNK = 4;
  localparam int NC    = W / CHUNK;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  final_cpa_seq_if #(.W(W)) bus ();

  final_cpa_seq #(.W(W), .CHUNK(CHUNK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [W-1:0] p;
    logic         ovf;
    int           lat;
    int           acc;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   hs_cyc = -100;
  int   ready_mode = 0;
  bit   mon_en = 1'b0;
  bit   prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Cycles from accept to out_valid, derived from the skip rule on plain integers.
  function automatic int ref_lat(input logic [W-1:0] s, input logic [W-1:0] c);
`ifdef CPA_ZERO_SKIP_EN
    longint a, b, lim;
    a = longint'(s);
    b = (longint'(c) << 1) & ((longint'(1) << W) - 1);
    for (int j = 1; j < NC; j++) begin
      lim = longint'(1) << (j * CHUNK);
      if ((a >> (j * CHUNK)) == 0 && (b >> (j * CHUNK)) == 0 && (a % lim + b % lim) < lim)
        return j;
    end
    return NC;
`else
    return NC + 0 * int'(s) + 0 * int'(c);
`endif
  endfunction

  function automatic exp_t model(input logic [W-1:0] s, input logic [W-1:0] c, input int acc);
    exp_t   e;
    longint total;
    total = longint'(s) + 2 * longint'(c);
    e.p   = W'(total);
    e.ovf = (total >= (longint'(1) << W));
    e.lat = ref_lat(s, c);
    e.acc = acc;
    return e;
  endfunction

  // Monitor: owns out_ready and pops the scoreboard on every output handshake.
  initial begin
    exp_t e;
    bus.out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        case (ready_mode)
          0:       bus.out_ready = 1'b1;
          1:       bus.out_ready = 1'($urandom_range(0, 1));
          default: bus.out_ready = 1'b0;
        endcase
        if (bus.out_valid && !prev_valid) begin
          if (q.size() == 0) chk("spurious_valid", 32'd1, 32'd0);
          else chk("latency", 32'(cyc - q[0].acc), 32'(q[0].lat));
        end
        if (bus.out_valid && bus.out_ready) begin
          if (q.size() == 0) begin
            chk("unexpected_result", 32'd1, 32'd0);
          end else begin
            e = q.pop_front();
            chk("out_p", 32'(bus.out_p), 32'(e.p));
            chk("out_ovf", 32'(bus.out_ovf), 32'(e.ovf));
          end
          hs_cyc = cyc + 1;
        end
        prev_valid = bus.out_valid;
      end
    end
  end

  task automatic send(input logic [W-1:0] s, input logic [W-1:0] c, input int gap,
                      input bit chk_follow);
    bit ok;
    ok = 1'b0;
    repeat (gap) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.row_s    = W'($urandom);
      bus.row_c    = W'($urandom);
    end
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.row_s    = s;
      bus.row_c    = c;
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      chk("accept_timeout", 32'd1, 32'd0);
    end else begin
      q.push_back(model(s, c, cyc + 1));
      if (chk_follow) chk("accept_after_idle", 32'(cyc + 1), 32'(hs_cyc + 1));
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.row_s    = W'($urandom);
    bus.row_c    = W'($urandom);
  endtask

  task automatic drain();
    for (int t = 0; t < 3000 && q.size() > 0; t++) @(negedge clk);
    chk("drain", 32'(q.size()), 32'd0);
  endtask

  initial begin
    logic [W-1:0] s, c;
    bus.in_valid = 1'b0;
    bus.row_s    = '0;
    bus.row_c    = '0;
    rst_n        = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_p", 32'(bus.out_p), 32'd0);
    chk("rst_out_ovf", 32'(bus.out_ovf), 32'd0);
    rst_n      = 1'b1;
    mon_en     = 1'b1;
    ready_mode = 0;

    send(16'h00FF, 16'h0001, 0, 1'b0);
    send(16'hFFFF, 16'h8000, 1, 1'b0);
    send(16'hFFFF, 16'h0001, 0, 1'b0);
    send(16'h0000, 16'h0000, 0, 1'b0);
    drain();

    // Output stalled in DONE while a new pair is already offered.
    ready_mode = 2;
    send(16'h1111, 16'h0222, 0, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.row_s    = 16'hABCD;
    bus.row_c    = 16'h0123;
    for (int t = 0; t < 20 && !bus.out_valid; t++) @(negedge clk);
    repeat (10) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
      chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
      chk("stall_out_p", 32'(bus.out_p), 32'h1555);
    end
    ready_mode = 0;
    send(16'hABCD, 16'h0123, 0, 1'b1);
    drain();

    // Reset in the second ADD cycle discards the operation.
    send(16'hFFFF, 16'h7FFF, 0, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_out_p", 32'(bus.out_p), 32'd0);
    chk("midrst_out_ovf", 32'(bus.out_ovf), 32'd0);
    q.delete();
    prev_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    send(16'h1234, 16'h0100, 0, 1'b0);
    drain();

    ready_mode = 1;
    for (int i = 0; i < 1000; i++) begin
      s = W'($urandom);
      c = W'($urandom);
      case ($urandom_range(0, 3))
        0: begin s = s & 16'h00FF; c = c & 16'h000F; end
        1: c = '0;
        default: ;
      endcase
      send(s, c, int'($urandom_range(0, 2)), 1'b0);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete, %0d checks done", n_chk);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/final_cpa_seq.md
FINAL_CPA_SEQ -- requirements
Module: final_cpa_seq

Interface
REQ-001 SHALL have parameter W, default 16, meaning width of the sum/carry rows and of the product; W SHALL be a multiple of CHUNK.
REQ-002 SHALL have parameter CHUNK, default 4, meaning bits resolved per ADD cycle.
REQ-003 SHALL use one clock; reset SHALL be asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  row_s/row_c are valid.
REQ-007 in_ready  output  1  block can accept a row pair.
REQ-008 row_s  input  W  sum row from the 4-2 compressor tree, weight 2^i per bit.
REQ-009 row_c  input  W  carry row from the compressor tree, unshifted; bit i has weight 2^(i+1).
REQ-010 out_valid  output  1  out_p/out_ovf are valid.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 out_p  output  W  (row_s + (row_c<<1)) mod 2^W.
REQ-013 out_ovf  output  1  true sum >= 2^W.

Function
REQ-014 SHALL implement the FSM states IDLE, ADD and DONE.
REQ-015 IDLE: in_ready=1; on in_valid&&in_ready, SHALL latch row_s, {row_c[W-2:0],1'b0} and row_c[W-1], clear chunk index k and carry, and go to ADD.
REQ-016 ADD: each cycle SHALL add chunk k of both operands plus carry, write CHUNK result bits to out_p[k*CHUNK +: CHUNK], update carry, and increment k.
REQ-017 ADD SHALL go to DONE after chunk W/CHUNK-1 is processed, unless REQ-025 ends it earlier.
REQ-018 On entry to DONE, out_ovf SHALL equal final carry OR latched row_c[W-1].
REQ-019 DONE: out_valid=1; out_p/out_ovf SHALL stay stable until out_valid&&out_ready, then go to IDLE.
REQ-020 in_ready SHALL be 0 in ADD and DONE; input changes there SHALL be ignored.
REQ-021 Latency without the macro SHALL be W/CHUNK cycles: accept at edge N gives out_valid high after edge N+W/CHUNK; throughput is one result per W/CHUNK+2 cycles with out_ready held high.
REQ-022 in_valid asserted in the same cycle as the DONE handshake SHALL NOT be accepted; it is taken in the following IDLE cycle.
REQ-023 Unprocessed out_p bits SHALL read 0 during ADD; out_p is don't-care to the consumer while out_valid=0.

Reset
REQ-024 rst_n low, at any time and in any state including mid-ADD, SHALL force IDLE, in_ready=1, out_valid=0, out_p=0, out_ovf=0, k=0 and carry=0; an in-flight operation is discarded.

Configuration
REQ-025 With CPA_ZERO_SKIP_EN defined: after processing chunk k, if carry=0 and all higher chunks of both latched operands are 0, the FSM SHALL go to DONE with the upper out_p bits 0 (latency 1..W/CHUNK cycles); results SHALL be identical to the build without the macro.
REQ-026 Without CPA_ZERO_SKIP_EN, latency SHALL always be exactly W/CHUNK cycles and no zero-detect logic is present.

Verification
REQ-027 row_s=0x00FF, row_c=0x0001 -> out_p=0x0101, out_ovf=0; out_valid 4 cycles after accept (3 with CPA_ZERO_SKIP_EN).
REQ-028 row_s=0xFFFF, row_c=0x8000 -> out_p=0xFFFF, out_ovf=1; row_s=0xFFFF, row_c=0x0001 -> out_p=0x0001, out_ovf=1.
REQ-029 row_s=0x0000, row_c=0x0000 -> out_p=0, out_ovf=0; latency 4 without the macro, 1 with it.
REQ-030 out_ready held 0 for 10 cycles in DONE with in_valid=1 and new data -> out_p stable, in_ready=0, new data accepted only after the out handshake and the following IDLE cycle.
REQ-031 rst_n pulsed low during the 2nd ADD cycle -> all outputs reset immediately, in_ready=1; the next row pair 0x1234/0x0100 -> out_p=0x1434, out_ovf=0.
REQ-032 1000 random row pairs with random in_valid/out_ready stalls -> every out_p/out_ovf matches the 18-bit golden sum; no result is lost or duplicated.
